elevator_scheduler: RTL and testbench

- Central car controller for one elevator serving NUM_FLOORS floors.
- Consumes per-floor hall requests (level, held by floor request blocks) and car-panel button pulses.
- Runs a SCAN (collective) policy: moves the car, opens and closes the door, and issues one-cycle clear pulses back to the floor blocks for each request served.

---
 rtl/elevator_scheduler.sv | 245 ++++++++++++++++++++++++
 tb/tb_elevator_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scheduler.sv
// ---------------------------------------------------------------------------
// elevator_scheduler
//   Central car controller for a single elevator. It runs a SCAN (collective)
//   policy: it moves the car, opens and closes the door, and sends one-cycle
//   clear pulses back to the per-floor hall request blocks.
//
// Optional build macro: ELEV_ESTOP_EN (adds estop input, estop_active output
//   and the freeze logic; undefined by default).
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-low reset
//   up_req        in   [NUM_FLOORS] level hall-up requests
//   dn_req        in   [NUM_FLOORS] level hall-down requests
//   car_req       in   [NUM_FLOORS] car-panel button pulses (latched here)
//   estop         in   (ELEV_ESTOP_EN only) emergency stop, active high
//   estop_active  out  (ELEV_ESTOP_EN only) estop delayed one cycle
//   current_floor out  [FLOOR_W] floor the car is at / last passed
//   dir_up        out  1 = travelling/serving up
//   moving        out  car in motion
//   door_open     out  door open
//   clr_up        out  [NUM_FLOORS] one-cycle hall-up served pulses
//   clr_dn        out  [NUM_FLOORS] one-cycle hall-down served pulses
//   car_pend      out  [NUM_FLOORS] latched car requests not yet served
// ---------------------------------------------------------------------------
module elevator_scheduler #(
    parameter int unsigned NUM_FLOORS    = 8,
    parameter int unsigned FLOOR_W       = 3,
    parameter int unsigned TRAVEL_CYCLES = 16,
    parameter int unsigned DOOR_CYCLES   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] up_req,
    input  logic [NUM_FLOORS-1:0] dn_req,
    input  logic [NUM_FLOORS-1:0] car_req,
`ifdef ELEV_ESTOP_EN
    input  logic                  estop,
    output logic                  estop_active,
`endif
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] clr_up,
    output logic [NUM_FLOORS-1:0] clr_dn,
    output logic [NUM_FLOORS-1:0] car_pend
);

    localparam int unsigned MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int unsigned TIMER_W = $clog2(MAX_CYC + 1);
    localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    state_t                  state_q, state_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [FLOOR_W-1:0]      floor_q, floor_d;
    logic                    dir_q, dir_d;
    logic                    moving_q, moving_d;
    logic                    door_q, door_d;
    logic [NUM_FLOORS-1:0]   clr_up_q, clr_up_d;
    logic [NUM_FLOORS-1:0]   clr_dn_q, clr_dn_d;
    logic [NUM_FLOORS-1:0]   car_pend_q, car_pend_d;

    logic [NUM_FLOORS-1:0]   pend, oh_cur, oh_nf, oh_sf;
    logic [FLOOR_W-1:0]      nf, serve_floor;
    logic                    above, below, at_end, pend_nf, ahead_nf, stop_nf;
    logic                    hold_up, hold_dn, hold_car;
    logic                    serve, freeze;

    function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        return NUM_FLOORS'(1) << f;
    endfunction

    // Floors strictly ahead of f in the given direction.
    function automatic logic [NUM_FLOORS-1:0] mask_ahead(input logic [FLOOR_W-1:0] f,
                                                         input logic up);
        logic [NUM_FLOORS-1:0] ones;
        ones = '1;
        if (up) return ones << ({1'b0, f} + (FLOOR_W+1)'(1));
        else    return ~(ones << f);
    endfunction

`ifdef ELEV_ESTOP_EN
    assign freeze = estop;
`else
    assign freeze = 1'b0;
`endif

    always_comb begin
        pend   = up_req | dn_req | car_pend_q;
        oh_cur = onehot(floor_q);
        above  = |(pend & mask_ahead(floor_q, 1'b1));
        below  = |(pend & mask_ahead(floor_q, 1'b0));
        // At an end floor the step is suppressed so the stop evaluation sees
        // the same floor with nothing ahead, which forces a stop (or idle).
        at_end = dir_q ? (floor_q == TOP_FLOOR) : (floor_q == '0);
        if (at_end)     nf = floor_q;
        else if (dir_q) nf = floor_q + FLOOR_W'(1);
        else            nf = floor_q - FLOOR_W'(1);
        oh_nf    = onehot(nf);
        pend_nf  = |(pend & oh_nf);
        ahead_nf = |(pend & mask_ahead(nf, dir_q));
        stop_nf  = (|(car_pend_q & oh_nf))
                 | (dir_q ? (|(up_req & oh_nf)) : (|(dn_req & oh_nf)))
                 | (pend_nf & ~ahead_nf);
        // A hall request still visible while its clear pulse is out is the
        // one just served; the floor block drops it a cycle later.
        hold_up  = dir_q  & (|(up_req & oh_cur & ~clr_up_q));
        hold_dn  = ~dir_q & (|(dn_req & oh_cur & ~clr_dn_q));
        hold_car = |(car_req & oh_cur);
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        floor_d     = floor_q;
        dir_d       = dir_q;
        moving_d    = moving_q;
        door_d      = door_q;
        clr_up_d    = '0;
        clr_dn_d    = '0;
        car_pend_d  = car_pend_q | car_req;
        serve       = 1'b0;
        serve_floor = floor_q;
        oh_sf       = '0;

        case (state_q)
            IDLE: begin
                if (!freeze) begin
                    if (|(pend & oh_cur)) begin
                        serve = 1'b1;
                    end else if (above && (dir_q || !below)) begin
                        dir_d    = 1'b1;
                        moving_d = 1'b1;
                        timer_d  = TRAVEL_LOAD;
                        state_d  = MOVE;
                    end else if (below) begin
                        dir_d    = 1'b0;
                        moving_d = 1'b1;
                        timer_d  = TRAVEL_LOAD;
                        state_d  = MOVE;
                    end
                end
            end
            MOVE: begin
                if (!freeze) begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - TIMER_W'(1);
                    end else begin
                        floor_d = nf;
                        if (stop_nf) begin
                            serve       = 1'b1;
                            serve_floor = nf;
                        end else if (!ahead_nf && !pend_nf) begin
                            // Requests withdrawn under way: nothing left to reach.
                            moving_d = 1'b0;
                            state_d  = IDLE;
                        end else begin
                            timer_d = TRAVEL_LOAD;
                        end
                    end
                end
            end
            DOOR: begin
                car_pend_d = car_pend_d & ~oh_cur;
                if (!freeze) begin
                    if (hold_up || hold_dn || hold_car) begin
                        timer_d = DOOR_LOAD;
                        if (hold_up) clr_up_d = oh_cur;
                        if (hold_dn) clr_dn_d = oh_cur;
                    end else if (timer_q == '0) begin
                        door_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Door entry: shared by arrival in MOVE and by a request at the idle floor.
        if (serve) begin
            oh_sf      = onehot(serve_floor);
            state_d    = DOOR;
            door_d     = 1'b1;
            moving_d   = 1'b0;
            timer_d    = DOOR_LOAD;
            car_pend_d = (car_pend_q & ~oh_sf) | car_req;
            if (dir_q) clr_up_d = up_req & oh_sf;
            else       clr_dn_d = dn_req & oh_sf;
            if (!(|(pend & mask_ahead(serve_floor, dir_q)))) begin
                dir_d = ~dir_q;
                if (dir_q) clr_dn_d = dn_req & oh_sf;
                else       clr_up_d = up_req & oh_sf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            floor_q    <= '0;
            dir_q      <= 1'b1;
            moving_q   <= 1'b0;
            door_q     <= 1'b0;
            clr_up_q   <= '0;
            clr_dn_q   <= '0;
            car_pend_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            floor_q    <= floor_d;
            dir_q      <= dir_d;
            moving_q   <= moving_d;
            door_q     <= door_d;
            clr_up_q   <= clr_up_d;
            clr_dn_q   <= clr_dn_d;
            car_pend_q <= car_pend_d;
        end
    end

`ifdef ELEV_ESTOP_EN
    logic estop_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) estop_q <= 1'b0;
        else      estop_q <= estop;
    end
    assign estop_active = estop_q;
`endif

    assign current_floor = floor_q;
    assign dir_up        = dir_q;
    assign moving        = moving_q;
    assign door_open     = door_q;
    assign clr_up        = clr_up_q;
    assign clr_dn        = clr_dn_q;
    assign car_pend      = car_pend_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// ---------------------------------------------------------------------------
// tb_elevator_scheduler
//   Directed bench for elevator_scheduler (8 floors, 16-cycle travel, 32-cycle
//   door). A table of single trips plus hand-written multi-cycle sequences.
//   The bench acts as the floor blocks: it drops a hall request once the
//   matching clear pulse is seen.
// ---------------------------------------------------------------------------
module tb_elevator_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] up_req, dn_req, car_req;
    logic [2:0] current_floor;
    logic       dir_up, moving, door_open;
    logic [7:0] clr_up, clr_dn, car_pend;
`ifdef ELEV_ESTOP_EN
    logic       estop, estop_active;
`endif

    int errors = 0;
    int checks = 0;
    int pulses_up[8];
    int pulses_dn[8];

    always #5 clk = ~clk;

    elevator_scheduler #(
        .NUM_FLOORS(8), .FLOOR_W(3), .TRAVEL_CYCLES(16), .DOOR_CYCLES(32)
    ) dut (
        .clk(clk), .rst(rst),
        .up_req(up_req), .dn_req(dn_req), .car_req(car_req),
`ifdef ELEV_ESTOP_EN
        .estop(estop), .estop_active(estop_active),
`endif
        .current_floor(current_floor), .dir_up(dir_up), .moving(moving),
        .door_open(door_open), .clr_up(clr_up), .clr_dn(clr_dn), .car_pend(car_pend)
    );

    typedef struct {
        int         kind;      // 0 hall-up, 1 hall-down, 2 car button
        int         fl;
        int         ex_floor;
        int         ex_ticks;  // edges from request to door_open
        logic       ex_dir;    // dir_up after door entry
        logic [7:0] ex_cu;
        logic [7:0] ex_cd;
    } trip_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_pulses();
        for (int i = 0; i < 8; i++) begin
            pulses_up[i] = 0;
            pulses_dn[i] = 0;
        end
    endtask

    function automatic int pulse_total();
        int s = 0;
        for (int i = 0; i < 8; i++) s += pulses_up[i] + pulses_dn[i];
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            if (clr_up[i]) pulses_up[i]++;
            if (clr_dn[i]) pulses_dn[i]++;
        end
        up_req = up_req & ~clr_up;
        dn_req = dn_req & ~clr_dn;
        check("inv.move_and_door", {31'b0, moving & door_open}, 32'd0);
        check("inv.clr_while_moving", {31'b0, moving & ((clr_up | clr_dn) != 8'h00)}, 32'd0);
    endtask

    task automatic wait_open(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!door_open && n < 400);
    endtask

    task automatic wait_close(output int m);
        m = 0;
        do begin
            tick();
            m++;
        end while (door_open && m < 200);
    endtask

    task automatic trip(input trip_t t, input string tag);
        int n;
        int m;
        clear_pulses();
        case (t.kind)
            0:       up_req  = up_req  | (8'd1 << t.fl);
            1:       dn_req  = dn_req  | (8'd1 << t.fl);
            default: car_req = car_req | (8'd1 << t.fl);
        endcase
        n = 0;
        do begin
            tick();
            car_req = '0;
            n++;
        end while (!door_open && n < 400);
        check({tag, ".ticks"},  n,             t.ex_ticks);
        check({tag, ".floor"},  current_floor, t.ex_floor);
        check({tag, ".dir"},    dir_up,        t.ex_dir);
        check({tag, ".clr_up"}, clr_up,        t.ex_cu);
        check({tag, ".clr_dn"}, clr_dn,        t.ex_cd);
        m = 0;
        do begin
            tick();
            m++;
            if (m == 1) check({tag, ".clr_one_cycle"}, clr_up | clr_dn, 32'd0);
        end while (door_open && m < 200);
        check({tag, ".door_len"}, m, 32);
        check({tag, ".car_pend"}, car_pend, 32'd0);
        check({tag, ".pulse_count"}, pulse_total(), 32'((t.ex_cu != 0) + (t.ex_cd != 0)));
    endtask

    trip_t tbl[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        logic [2:0] fz;

        tbl[0] = '{2, 0, 0, 50,  1'b1, 8'h00, 8'h00};  // from 3 (down): car 0
        tbl[1] = '{1, 7, 7, 113, 1'b0, 8'h00, 8'h80};  // top floor, reverse there
        tbl[2] = '{2, 4, 4, 50,  1'b1, 8'h00, 8'h00};  // from 7: car 4
        tbl[3] = '{0, 2, 2, 33,  1'b1, 8'h04, 8'h00};  // up-call below: reverse at 2
        tbl[4] = '{0, 2, 2, 1,   1'b0, 8'h04, 8'h00};  // call at current floor
        tbl[5] = '{1, 0, 0, 33,  1'b1, 8'h00, 8'h01};  // bottom floor

        rst = 1'b0; up_req = '0; dn_req = '0; car_req = '0;
`ifdef ELEV_ESTOP_EN
        estop = 1'b0;
`endif
        clear_pulses();
        repeat (3) tick();
        check("reset.floor",    current_floor, 32'd0);
        check("reset.dir_up",   dir_up,        32'd1);
        check("reset.moving",   moving,        32'd0);
        check("reset.door",     door_open,     32'd0);
        check("reset.clr",      {clr_up, clr_dn}, 32'd0);
        check("reset.car_pend", car_pend,      32'd0);
        rst = 1'b1;
        tick();

        // Single hall-up call three floors away.
        clear_pulses();
        up_req = 8'h08;
        tick();
        check("t1.moving_next", moving, 32'd1);
        check("t1.dir_up",      dir_up, 32'd1);
        n = 1;
        while (current_floor != 3'd3 && n < 200) begin
            tick();
            n++;
        end
        check("t1.travel_edges", n - 1, 32'd48);
        check("t1.door_open",    door_open, 32'd1);
        check("t1.clr_up",       clr_up,    32'h08);
        wait_close(m);
        check("t1.door_len",   m, 32'd32);
        check("t1.clr_up3_once", pulses_up[3], 32'd1);
        check("t1.pulses_total", pulse_total(), 32'd1);
        check("t1.dir_after",  dir_up, 32'd0);

        for (int i = 0; i < 6; i++) trip(tbl[i], $sformatf("tbl%0d", i));

        // Car call to 5, hall-down at 2 appears on the way up.
        clear_pulses();
        car_req = 8'h20;
        tick();
        car_req = '0;
        check("t2.car_pend_set", car_pend, 32'h20);
        n = 1;
        while (current_floor != 3'd1 && n < 200) begin
            tick();
            n++;
        end
        dn_req = 8'h04;
        while (!door_open && n < 400) begin
            tick();
            n++;
        end
        check("t2.first_stop",  current_floor, 32'd5);
        check("t2.ticks",       n, 32'd82);
        check("t2.car_pend_clr", car_pend, 32'd0);
        check("t2.reverse",     dir_up, 32'd0);
        wait_close(m);
        wait_open(n);
        check("t2.second_stop", current_floor, 32'd2);
        check("t2.ticks2",      n, 32'd49);
        check("t2.clr_dn",      clr_dn, 32'h04);
        check("t2.dn2_once_pulses", pulse_total(), 32'd1);
        wait_close(m);

        // Door hold reload at floor 2.
        clear_pulses();
        up_req = 8'h04;
        wait_open(n);
        check("t5.ticks",  n, 32'd1);
        check("t5.clr_up", clr_up, 32'h04);
        repeat (10) tick();
        check("t5.mid_hold", door_open, 32'd1);
        car_req = 8'h04;
        tick();
        car_req = '0;
        repeat (31) tick();
        check("t5.still_open", door_open, 32'd1);
        tick();
        check("t5.closed",   door_open, 32'd0);
        check("t5.car_pend", car_pend,  32'd0);
        check("t5.one_pulse", pulse_total(), 32'd1);

        // Idle at 4 heading up, up-call at 6 and down-call at 1 together.
        trip('{1, 7, 7, 81, 1'b0, 8'h00, 8'h80}, "t3.setup_top");
        trip('{2, 4, 4, 50, 1'b1, 8'h00, 8'h00}, "t3.setup_4");
        clear_pulses();
        up_req = 8'h40;
        dn_req = 8'h02;
        wait_open(n);
        check("t3.first_floor", current_floor, 32'd6);
        check("t3.first_ticks", n, 32'd33);
        check("t3.clr_up6",     clr_up, 32'h40);
        check("t3.clr_dn_none", clr_dn, 32'h00);
        wait_close(m);
        wait_open(n);
        check("t3.second_floor", current_floor, 32'd1);
        check("t3.second_ticks", n, 32'd81);
        check("t3.clr_dn1",      clr_dn, 32'h02);
        check("t3.dir_after",    dir_up, 32'd1);
        wait_close(m);

        // Bottom floor: no step below 0.
        trip('{2, 0, 0, 18, 1'b1, 8'h00, 8'h00}, "t4.to0");
        repeat (40) tick();
        check("t4.floor0_stays", current_floor, 32'd0);
        check("t4.not_moving",   moving, 32'd0);
        check("t4.dir_kept",     dir_up, 32'd1);

        // Asynchronous reset between floors 2 and 3.
        clear_pulses();
        car_req = 8'h20;
        tick();
        car_req = '0;
        n = 0;
        while (!(current_floor == 3'd2 && moving) && n < 200) begin
            tick();
            n++;
        end
        check("t6.pre_floor",  current_floor, 32'd2);
        repeat (5) tick();
        check("t6.pre_moving", moving, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t6.floor",    current_floor, 32'd0);
        check("t6.dir_up",   dir_up,    32'd1);
        check("t6.moving",   moving,    32'd0);
        check("t6.door",     door_open, 32'd0);
        check("t6.clr",      {clr_up, clr_dn}, 32'd0);
        check("t6.car_pend", car_pend,  32'd0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (5) tick();
        check("t6.stay_idle", {moving, door_open, current_floor}, 32'd0);
        check("t6.no_pulses", pulse_total(), 32'd0);

`ifdef ELEV_ESTOP_EN
        clear_pulses();
        up_req = 8'h08;
        n = 0;
        repeat (11) begin
            tick();
            n++;
        end
        estop = 1'b1;
        tick();
        n++;
        fz = current_floor;
        check("es.active", estop_active, 32'd1);
        repeat (9) begin
            tick();
            n++;
        end
        check("es.frozen_floor", current_floor, fz);
        check("es.still_moving", moving, 32'd1);
        estop = 1'b0;
        while (!door_open && n < 400) begin
            tick();
            n++;
        end
        check("es.ticks", n, 32'd59);
        check("es.floor", current_floor, 32'd3);
        check("es.inactive", estop_active, 32'd0);
        wait_close(m);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
